// File: rtl/gauss_frame_sched.sv
// gauss_frame_sched: raster-walks a frame, feeding 3x3 windows to the Gaussian core and writing results (0 on borders).
module gauss_frame_sched #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int ADDR_W   = 17,
  parameter int CORE_TMO = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic [71:0]       win_o,
  output logic              core_en_o,
  input  logic              core_done_i,
  input  logic [7:0]        core_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int TW = $clog2(CORE_TMO + 1);
  localparam logic [ADDR_W-1:0] WA  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WA2 = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] NW1 = ADDR_W'(IMG_W + 1);
  typedef enum logic [3:0] {IDLE, BORDER, FILL9, FILL3, ISSUE, WAIT, WRITE, NEXT, FIN} state_t;
  state_t st, nx;
  logic [RW-1:0] row, n_row;
  logic [CW-1:0] col, n_col;
  logic [ADDR_W-1:0] ctr, row_off;
  logic [3:0] k;
  logic [TW-1:0] tmo;
  logic [7:0] res;
  logic [71:0] win, shifted;
  logic err, last_col, last_row, n_border, timeout;
  logic [1:0] dr, dc;
  logic [6:0] cap_lsb;
  always_comb begin
    last_col = col == CW'(IMG_W - 1);
    last_row = row == RW'(IMG_H - 1);
    n_col    = last_col ? '0 : col + 1'b1;
    n_row    = last_col ? row + 1'b1 : row;
    n_border = n_row == '0 || n_row == RW'(IMG_H - 1) || n_col == '0 || n_col == CW'(IMG_W - 1);
    timeout  = st == WAIT && !core_done_i && tmo == TW'(CORE_TMO - 1);
    // window position of the k-th read: FILL9 walks all nine, FILL3 only the right column
    dr       = st == FILL3 ? k[1:0] : k < 4'd3 ? 2'd0 : k < 4'd6 ? 2'd1 : 2'd2;
    dc       = st == FILL3 ? 2'd2 : k < 4'd3 ? k[1:0] : k < 4'd6 ? 2'(k - 4'd3) : 2'(k - 4'd6);
    row_off  = dr == 2'd0 ? '0 : dr == 2'd1 ? WA : WA2;
    cap_lsb  = st == FILL3 ? 7'(24 * (k - 4'd1) + 16) : 7'(8 * (k - 4'd1));
    shifted  = {win[71:64], win[71:56], win[47:40], win[47:32], win[23:16], win[23:8]};
  end
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = start_i ? BORDER : IDLE;
      BORDER:  nx = NEXT;
      FILL9:   nx = k == 4'd9 ? ISSUE : FILL9;
      FILL3:   nx = k == 4'd3 ? ISSUE : FILL3;
      ISSUE:   nx = WAIT;
      WAIT:    nx = core_done_i || timeout ? WRITE : WAIT;
      WRITE:   nx = NEXT;
      NEXT:    nx = last_row && last_col ? FIN : n_border ? BORDER : n_col == CW'(1) ? FILL9 : FILL3;
      FIN:     nx = IDLE;
      default: nx = IDLE;
    endcase
    rd_en_o   = (st == FILL9 && k < 4'd9) || (st == FILL3 && k < 4'd3);
    rd_addr_o = rd_en_o ? ctr + row_off + ADDR_W'(dc) - NW1 : '0;
    wr_en_o   = st == BORDER || st == WRITE;
    wr_addr_o = wr_en_o ? ctr : '0;
    wr_data_o = st == WRITE ? res : 8'd0;
    core_en_o = st == ISSUE;
    done_o    = st == FIN;
    busy_o    = st != IDLE && st != FIN;
    err_o     = err;
    win_o     = win;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) st <= IDLE;
    else st <= nx;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row <= '0;
      col <= '0;
      ctr <= '0;
      k   <= '0;
      tmo <= '0;
      res <= 8'd0;
      win <= '0;
      err <= 1'b0;
    end else begin
      if (st == IDLE && start_i) begin
        row <= '0;
        col <= '0;
        ctr <= '0;
        err <= 1'b0;
      end
      // read data arrives one cycle after its strobe, so capture lags issue by one step
      if (st == FILL9 || st == FILL3) begin
        k <= nx == ISSUE ? '0 : k + 1'b1;
        if (k != 4'd0) win[cap_lsb +: 8] <= rd_data_i;
        else if (st == FILL3) win <= shifted;
      end
      if (st == ISSUE) tmo <= '0;
      if (st == WAIT) begin
        tmo <= tmo + 1'b1;
        res <= core_done_i ? core_data_i : 8'd0;
        if (timeout) err <= 1'b1;
      end
      if (st == NEXT) begin
        row <= n_row;
        col <= n_col;
        ctr <= ctr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gauss_frame_sched.sv
// tb_gauss_frame_sched: directed checks of the frame scheduler on a 5x4 frame with RAM and core models.
module tb_gauss_frame_sched;
  localparam int W = 5, H = 4, N = W * H, AW = 17;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic busy_o, done_o, err_o, rd_en_o, core_en_o, wr_en_o;
  logic core_done_i = 1'b0;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [7:0] rd_data_i = 8'd0, core_data_i = 8'd0, wr_data_o;
  logic [71:0] win_o;
  gauss_frame_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CORE_TMO(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .win_o(win_o),
    .core_en_o(core_en_o), .core_done_i(core_done_i), .core_data_i(core_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );
  always #5 clk_i = ~clk_i;
  int checks = 0, failures = 0;
  int psel = 0, cmode = 0, lat = 3;
  int cyc = 0, wr_cnt, rd_cnt, ovl, ord_err, iss, done_cnt, t_iss, t_w, ccnt = 0;
  logic err_w;
  logic [71:0] win2;
  logic [7:0] dst [N];
  logic [7:0] cval = 8'd0;
  task automatic check(string tag, logic [71:0] got, logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] src(int a);
    return psel == 0 ? 8'(a) : 8'(a * 37 + 11);
  endfunction
  function automatic logic [7:0] fn(logic [71:0] w);
    logic [7:0] s;
    s = 8'd0;
    if (cmode == 0) return w[39:32];
    for (int j = 0; j < 9; j++) s = s + 8'(j + 1) * w[8*j +: 8];
    return s;
  endfunction
  function automatic logic [7:0] exp_pix(int a);
    int r, c;
    logic [71:0] w;
    r = a / W;
    c = a % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1 || cmode == 2) return 8'd0;
    for (int j = 0; j < 9; j++) w[8*j +: 8] = src((r + j / 3 - 1) * W + c + j % 3 - 1);
    return fn(w);
  endfunction
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= src(int'(rd_addr_o));
    core_done_i <= 1'b0;
    if (core_en_o) begin
      ccnt <= lat;
      cval <= fn(win_o);
    end else if (ccnt > 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1 && cmode != 2) begin
        core_done_i <= 1'b1;
        core_data_i <= cval;
      end
    end
  end
  always @(negedge clk_i) begin
    if (wr_en_o) begin
      if (int'(wr_addr_o) != wr_cnt) ord_err++;
      if (int'(wr_addr_o) < N) dst[int'(wr_addr_o)] = wr_data_o;
      if (int'(wr_addr_o) == W + 1) begin
        t_w = cyc;
        err_w = err_o;
      end
      wr_cnt++;
    end
    if (rd_en_o) rd_cnt++;
    if (rd_en_o && wr_en_o) ovl++;
    if (core_en_o) begin
      iss++;
      if (iss == 1) t_iss = cyc;
      if (iss == 2) win2 = win_o;
    end
    if (done_o) done_cnt++;
    cyc++;
  end
  task automatic clear();
    wr_cnt = 0; rd_cnt = 0; ovl = 0; ord_err = 0; iss = 0; done_cnt = 0; t_iss = 0; t_w = 0;
    err_w = 1'b0;
    win2 = '0;
    for (int a = 0; a < N; a++) dst[a] = 'x;
  endtask
  task automatic wait_done(string tag);
    int i;
    for (i = 0; i < 5000 && !done_o; i++) @(negedge clk_i);
    check({tag, "_bound"}, i < 5000, 1);
  endtask
  task automatic run_frame(string tag, logic exp_err);
    clear();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    wait_done(tag);
    repeat (3) @(posedge clk_i);
    #1;
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_err"}, err_o, exp_err);
  endtask
  task automatic check_frame(string tag);
    check({tag, "_writes"}, wr_cnt, N);
    check({tag, "_order"}, ord_err, 0);
    check({tag, "_rd_wr_overlap"}, ovl, 0);
    check({tag, "_reads"}, rd_cnt, 2 * (9 + 3 * (W - 3)));
    for (int a = 0; a < N; a++) check($sformatf("%s_px%0d", tag, a), dst[a], exp_pix(a));
  endtask
  initial begin
    int i;
    clear();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ctrl", {busy_o, done_o, err_o, rd_en_o, wr_en_o, core_en_o}, 0);
    check("rst_win", win_o, 0);
    check("rst_bus", {rd_addr_o, wr_addr_o, wr_data_o}, 0);
    rst_i = 1'b0;
    // ramp source, core echoes the centre byte
    psel = 0; cmode = 0;
    run_frame("ramp", 1'b0);
    check_frame("ramp");
    check("ramp_win_c12", win2, 72'h0D0C0B080706030201);
    // hashed source, core returns a weighted sum of all nine bytes
    psel = 1; cmode = 1;
    run_frame("wsum", 1'b0);
    check_frame("wsum");
    check("wsum_latency", t_w - t_iss, 5);
    // core never answers
    cmode = 2;
    run_frame("tmo", 1'b1);
    check_frame("tmo");
    check("tmo_wait_len", t_w - t_iss, 65);
    check("tmo_err_at_write", err_w, 1);
    // reset during WAIT, then a clean frame
    cmode = 1;
    clear();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    for (i = 0; i < 2000 && !core_en_o; i++) @(negedge clk_i);
    check("rstw_issue_bound", i < 2000, 1);
    @(posedge clk_i); #3 rst_i = 1'b1;
    #1;
    check("rstw_ctrl", {busy_o, done_o, err_o, rd_en_o, wr_en_o, core_en_o}, 0);
    check("rstw_win", win_o, 0);
    check("rstw_writes_before", wr_cnt, W + 1);
    repeat (10) @(posedge clk_i);
    #1;
    check("rstw_no_write", wr_cnt, W + 1);
    check("rstw_no_done", done_cnt, 0);
    rst_i = 1'b0;
    run_frame("rstw_after", 1'b0);
    check_frame("rstw_after");
    // start held high across a whole frame, after a timeout frame leaves err set
    cmode = 2;
    run_frame("tmo2", 1'b1);
    cmode = 1;
    clear();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1;
    check("held_busy", busy_o, 1);
    check("held_err_cleared", err_o, 0);
    wait_done("held1");
    check("held_fin_busy", busy_o, 0);
    check("held_one_frame", wr_cnt, N);
    check("held_order", ord_err, 0);
    @(negedge clk_i);
    check("held_idle", {busy_o, done_o}, 0);
    @(negedge clk_i);
    check("held_restart", {busy_o, wr_en_o, wr_addr_o}, {2'b11, 17'd0});
    start_i = 1'b0;
    wait_done("held2");
    @(posedge clk_i); #1;
    check("held_two_dones", done_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
